rotor_stepper: RTL and testbench
================================

ROTOR_STEPPER -- requirements
Module: rotor_stepper

Interface
REQ-001 SHALL have parameter NOTCH_R1, default 16, fast-rotor turnover position (0..25).
REQ-002 SHALL have parameter NOTCH_R2, default 4, middle-rotor turnover position (0..25).
REQ-003 SHALL have parameter SETTLE_CYC, default 2, cycles the new positions are held before pos_valid (range 1..15).
REQ-004 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port key_valid  input  1  keypress request.
REQ-007 SHALL have port key_ready  output  1  stepper can accept a keypress.
REQ-008 SHALL have port load_en  input  1  load initial rotor positions.
REQ-009 SHALL have ports load_r1, load_r2, load_r3  input  5 each  initial positions.
REQ-010 SHALL have ports pos_r1, pos_r2, pos_r3  output  5 each  current positions, driven to the forward and reverse rotor stages.
REQ-011 SHALL have port pos_valid  output  1  one-cycle pulse: positions stable, rotor path output may be sampled.

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, DONE.
REQ-013 IDLE: key_ready=1; key_valid=1 at an edge accepts a keypress, steps rotors at that same edge, enters SETTLE.
REQ-014 SETTLE: key_ready=0; stays exactly SETTLE_CYC cycles via down-counter, then enters DONE.
REQ-015 DONE: pos_valid=1 for exactly one cycle, key_ready=0, returns to IDLE next edge.
REQ-016 pos_valid SHALL assert in the cycle after the edge accept+SETTLE_CYC; key_valid outside IDLE SHALL be ignored (not queued).
REQ-017 Stepping: r1 SHALL always advance by 1.
REQ-018 r2 SHALL advance when pos_r1==NOTCH_R1 (pre-step value), or per REQ-027.
REQ-019 r3 SHALL advance per REQ-027/REQ-028.
REQ-020 Every position SHALL wrap 25 -> 0; outputs never exceed 25.
REQ-021 load_en SHALL be honoured only in IDLE; sets positions at the edge, no step, no pos_valid.
REQ-022 load_en and key_valid together in IDLE: load SHALL win, keypress dropped.
REQ-023 Load values 26..31 SHALL be reduced by 26 (26->0 ... 31->5).

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, pos_r1/r2/r3=0, pos_valid=0, settle counter=0.
REQ-025 key_ready SHALL be 0 while rst_n is low and 1 from the first cycle after release.
REQ-026 Reset during SETTLE or DONE SHALL abort the keypress; no pos_valid is emitted.

Configuration
REQ-027 With STEPPER_DOUBLE_STEP_EN defined: when pos_r2==NOTCH_R2 (pre-step), both r2 and r3 SHALL advance (Enigma double-step anomaly), in addition to REQ-018.
REQ-028 Without STEPPER_DOUBLE_STEP_EN: pure odometer; r3 SHALL advance only when pos_r1==NOTCH_R1 and pos_r2==NOTCH_R2; r2 steps only per REQ-018.

Structure
REQ-029 Package enigma_pkg SHALL hold LETTER_W=5, ALPHABET=26, default notch constants, and the FSM state enum.
REQ-030 Sub-module rotor_pos_counter (mod-26 counter with step, load, async reset) SHALL be instantiated three times.

Verification
REQ-031 Reset then key press -> positions (r3,r2,r1)=(0,0,1), pos_valid exactly SETTLE_CYC+1 cycles after accept edge.
REQ-032 Load (0,3,16), press -> (0,4,17); press again -> (1,5,18) with macro, (0,4,18) without.
REQ-033 Load (25,25,25) with NOTCH_R1=25, NOTCH_R2=25, macro off, press -> (0,0,0).
REQ-034 Load values (31,26,27) -> (5,0,1); load_en+key_valid same cycle -> load applied, no step, no pos_valid.
REQ-035 key_valid held high through SETTLE -> exactly one step per IDLE acceptance; key_ready low during SETTLE/DONE.
REQ-036 rst_n low in SETTLE -> positions 0 immediately, no pos_valid, key_ready 1 after release.

Source files
------------

// File: rtl/enigma_pkg.sv
// enigma_pkg: shared widths, alphabet size, default turnover notches, stepper FSM states
package enigma_pkg;
    localparam int LETTER_W     = 5;
    localparam int ALPHABET     = 26;
    localparam int NOTCH_R1_DEF = 16;
    localparam int NOTCH_R2_DEF = 4;

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} stepper_state_t;

    // Out-of-range letters 26..31 wrap back into 0..5
    function automatic logic [LETTER_W-1:0] fold26(input logic [LETTER_W-1:0] v);
        return (v >= LETTER_W'(ALPHABET)) ? v - LETTER_W'(ALPHABET) : v;
    endfunction
endpackage

// File: rtl/rotor_pos_counter.sv
// rotor_pos_counter: mod-26 rotor position with load (priority) and single step
// Ports: clk, rst_n (async, active-low), step, load, load_val[4:0] -> pos[4:0]
module rotor_pos_counter
    import enigma_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step,
    input  logic                load,
    input  logic [LETTER_W-1:0] load_val,
    output logic [LETTER_W-1:0] pos
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            pos <= '0;
        else if (load)
            pos <= fold26(load_val);
        else if (step)
            pos <= (pos == LETTER_W'(ALPHABET - 1)) ? '0 : pos + 1'b1;
endmodule

// File: rtl/rotor_stepper.sv
// rotor_stepper: three-rotor Enigma stepping controller with settle delay and pos_valid pulse
// Ports: clk, rst_n (async, active-low), key_valid/key_ready handshake, load_en + load_r1..r3,
//        pos_r1..r3 current positions, pos_valid one-cycle "positions stable" pulse.
// Option: STEPPER_DOUBLE_STEP_EN enables the middle-rotor double-step anomaly;
//         undefined gives a pure odometer.
module rotor_stepper
    import enigma_pkg::*;
#(
    parameter int NOTCH_R1   = NOTCH_R1_DEF,
    parameter int NOTCH_R2   = NOTCH_R2_DEF,
    parameter int SETTLE_CYC = 2
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic                load_en,
    input  logic [LETTER_W-1:0] load_r1,
    input  logic [LETTER_W-1:0] load_r2,
    input  logic [LETTER_W-1:0] load_r3,
    output logic [LETTER_W-1:0] pos_r1,
    output logic [LETTER_W-1:0] pos_r2,
    output logic [LETTER_W-1:0] pos_r3,
    output logic                pos_valid
);
    stepper_state_t state;
    logic [3:0]     cnt;
    logic           load, accept, n1, n2, r2_step, r3_step;

    // Load beats a simultaneous keypress; neither is seen outside IDLE
    assign load   = load_en && state == IDLE;
    assign accept = key_valid && key_ready && state == IDLE && !load_en;
    assign n1     = pos_r1 == LETTER_W'(NOTCH_R1);
    assign n2     = pos_r2 == LETTER_W'(NOTCH_R2);
`ifdef STEPPER_DOUBLE_STEP_EN
    // Middle rotor at its notch drags itself and the slow rotor along
    assign r2_step = accept && (n1 || n2);
    assign r3_step = accept && n2;
`else
    assign r2_step = accept && n1;
    assign r3_step = accept && n1 && n2;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pos_valid <= 1'b0;
            key_ready <= 1'b0;
        end else begin
            pos_valid <= 1'b0;
            case (state)
                IDLE:
                    if (accept) begin
                        state     <= SETTLE;
                        cnt       <= 4'(SETTLE_CYC);
                        key_ready <= 1'b0;
                    end else
                        key_ready <= 1'b1;
                SETTLE:
                    if (cnt == 4'd1) begin
                        state     <= DONE;
                        cnt       <= '0;
                        pos_valid <= 1'b1;
                    end else
                        cnt <= cnt - 4'd1;
                DONE: begin
                    state     <= IDLE;
                    key_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end

    rotor_pos_counter u_r1 (.clk(clk), .rst_n(rst_n), .step(accept),  .load(load), .load_val(load_r1), .pos(pos_r1));
    rotor_pos_counter u_r2 (.clk(clk), .rst_n(rst_n), .step(r2_step), .load(load), .load_val(load_r2), .pos(pos_r2));
    rotor_pos_counter u_r3 (.clk(clk), .rst_n(rst_n), .step(r3_step), .load(load), .load_val(load_r3), .pos(pos_r3));
endmodule

// File: tb/tb_rotor_stepper.sv
// tb_rotor_stepper: directed + randomized checks of two stepper instances against a rule-level model
module tb_rotor_stepper;
    localparam int S = 2;

    logic       clk = 0, rst_n = 1, key_valid = 0, load_en = 0;
    logic [4:0] load_r1 = 0, load_r2 = 0, load_r3 = 0;
    logic [4:0] a1, a2, a3, b1, b2, b3;
    logic       ra, rb, va, vb;
    int         checks = 0, failures = 0;
    int         m[2][3];
    int         notch[2][2] = '{'{16, 4}, '{25, 25}};

    always #5 clk = ~clk;

    rotor_stepper #(.SETTLE_CYC(S)) dut_a (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(ra), .load_en(load_en),
        .load_r1(load_r1), .load_r2(load_r2), .load_r3(load_r3),
        .pos_r1(a1), .pos_r2(a2), .pos_r3(a3), .pos_valid(va));

    rotor_stepper #(.NOTCH_R1(25), .NOTCH_R2(25), .SETTLE_CYC(S)) dut_b (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(rb), .load_en(load_en),
        .load_r1(load_r1), .load_r2(load_r2), .load_r3(load_r3),
        .pos_r1(b1), .pos_r2(b2), .pos_r3(b3), .pos_valid(vb));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag);
        chk({tag, ".a.r1"}, a1, m[0][0]); chk({tag, ".a.r2"}, a2, m[0][1]); chk({tag, ".a.r3"}, a3, m[0][2]);
        chk({tag, ".b.r1"}, b1, m[1][0]); chk({tag, ".b.r2"}, b2, m[1][1]); chk({tag, ".b.r3"}, b3, m[1][2]);
    endtask

    task automatic chk_hs(input string tag, input int ready, input int valid);
        chk({tag, ".a.ready"}, ra, ready); chk({tag, ".b.ready"}, rb, ready);
        chk({tag, ".a.pv"}, va, valid);    chk({tag, ".b.pv"}, vb, valid);
    endtask

    // One keypress as the machine rules describe it, from the pre-press positions
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            bit t1 = m[d][0] == notch[d][0];
            bit t2 = m[d][1] == notch[d][1];
            bit s2, s3;
`ifdef STEPPER_DOUBLE_STEP_EN
            s2 = t1 || t2;
            s3 = t2;
`else
            s2 = t1;
            s3 = t1 && t2;
`endif
            m[d][0] = (m[d][0] + 1) % 26;
            if (s2) m[d][1] = (m[d][1] + 1) % 26;
            if (s3) m[d][2] = (m[d][2] + 1) % 26;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) for (int i = 0; i < 3; i++) m[d][i] = 0;
    endtask

    task automatic press(input string tag, input bit hold);
        key_valid = 1;
        tick();
        if (!hold) key_valid = 0;
        model_step();
        chk_pos({tag, ".accept"});
        chk_hs({tag, ".accept"}, 0, 0);
        for (int k = 1; k <= S; k++) begin
            tick();
            chk_hs({tag, ".settle"}, 0, (k == S) ? 1 : 0);
            chk_pos({tag, ".settle"});
        end
        key_valid = 0;
        tick();
        chk_hs({tag, ".idle"}, 1, 0);
        chk_pos({tag, ".idle"});
    endtask

    task automatic load(input string tag, input int v1, input int v2, input int v3, input bit with_key);
        load_r1 = 5'(v1); load_r2 = 5'(v2); load_r3 = 5'(v3);
        load_en = 1;
        key_valid = with_key;
        tick();
        load_en = 0;
        key_valid = 0;
        for (int d = 0; d < 2; d++) begin
            m[d][0] = v1 % 26; m[d][1] = v2 % 26; m[d][2] = v3 % 26;
        end
        chk_pos({tag, ".load"});
        chk_hs({tag, ".load"}, 1, 0);
        tick();
        chk_pos({tag, ".after"});
        chk_hs({tag, ".after"}, 1, 0);
    endtask

    initial begin
        model_reset();
        #2 rst_n = 0;
        #1;
        chk_pos("rst");
        chk_hs("rst", 0, 0);
        tick();
        tick();
        chk_hs("rst_hold", 0, 0);
        rst_n = 1;
        tick();
        chk_hs("rst_release", 1, 0);
        chk_pos("rst_release");

        press("first", 0);
        chk("first.r1", a1, 1);

        load("l0316", 16, 3, 0, 0);
        press("p1", 0);
        chk("p1.r2", a2, 4);
        press("p2", 0);
`ifdef STEPPER_DOUBLE_STEP_EN
        chk("p2.r3", a3, 1);
        chk("p2.r2", a2, 5);
`else
        chk("p2.r3", a3, 0);
        chk("p2.r2", a2, 4);
`endif

        load("wrap", 25, 25, 25, 0);
        press("wrap", 0);
        chk("wrap.b.r3", b3, 0);

        load("fold", 27, 26, 31, 1);
        chk("fold.r3", a3, 5);

        press("hold", 1);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0)
                load("rl", $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom_range(0, 1)));
            press("rp", 1'($urandom_range(0, 1)));
        end

        load("pre_abort", 15, 3, 7, 0);
        key_valid = 1;
        tick();
        key_valid = 0;
        tick();
        rst_n = 0;
        model_reset();
        #1;
        chk_pos("abort");
        chk_hs("abort", 0, 0);
        tick();
        chk_hs("abort_hold", 0, 0);
        rst_n = 1;
        for (int k = 0; k < S + 2; k++) begin
            tick();
            chk_hs("abort_after", 1, 0);
            chk_pos("abort_after");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
